// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA key-setup datapath: the coprime-exponent
// checker FSM states, the default operand width and the worst-case GCD latency.
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECHK,
    ST_SHIFT,
    ST_REDUCE,
    ST_FINISH
  } state_t;

  localparam int RSA_W     = 256;
  localparam int RSA_CNT_W = 10;

  // Binary GCD removes at least one operand bit per SHIFT/REDUCE cycle, plus the
  // start, PRECHK, final REDUCE and FINISH cycles.
  function automatic int max_latency(input int width);
    return 2 * width + 4;
  endfunction

  localparam int RSA_MAX_LAT = max_latency(RSA_W);

endpackage

// File: rtl/coprime_exp_check_if.sv
// Request/result bundle between the key-generation controller and coprime_exp_check.
// The cycles signal exists only when COPRIME_CYCLE_CNT_EN is defined.
interface coprime_exp_check_if
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_W,
  parameter int CNT_W = RSA_CNT_W
) ();

  logic             start;
  logic [WIDTH-1:0] e;
  logic             e_is_prime;
  logic [WIDTH-1:0] phi;
  logic             busy;
  logic             done;
  logic             e_valid;
  logic [WIDTH-1:0] gcd_out;
`ifdef COPRIME_CYCLE_CNT_EN
  logic [CNT_W-1:0] cycles;

  modport master (output start, e, e_is_prime, phi,
                  input  busy, done, e_valid, gcd_out, cycles);
  modport slave  (input  start, e, e_is_prime, phi,
                  output busy, done, e_valid, gcd_out, cycles);
`else
  modport master (output start, e, e_is_prime, phi,
                  input  busy, done, e_valid, gcd_out);
  modport slave  (input  start, e, e_is_prime, phi,
                  output busy, done, e_valid, gcd_out);
`endif

endinterface

// File: rtl/gcd_step.sv
// One REDUCE step of the binary (Stein) GCD: next (a, b) and the termination flag.
// Purely combinational so the step rule can be exercised in isolation.
module gcd_step #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic             term
);

  assign term = (a == '0) || (b == '0);

  // NOTE: every output gets a default first so no path through the if-chain leaves
  // a value unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    a_nxt = a;
    b_nxt = b;
    if (!term) begin
      if (!a[0])       a_nxt = a >> 1;
      else if (!b[0])  b_nxt = b >> 1;
      else if (a >= b) a_nxt = (a - b) >> 1;
      else             b_nxt = (b - a) >> 1;
    end
  end

endmodule

// File: rtl/coprime_exp_check.sv
// Checks that e is a usable RSA public exponent: prime, 1 < e < phi, gcd(e, phi) == 1,
// using one binary-GCD step per cycle. Optional cycle counter: COPRIME_CYCLE_CNT_EN.
module coprime_exp_check
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_W,
  parameter int CNT_W = RSA_CNT_W
) (
  input logic                clk,
  input logic                rst_n,
  coprime_exp_check_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] a, b;
  logic [CNT_W-1:0] k;
  logic             prime_flag;

  logic             busy_q, done_q, e_valid_q;
  logic [WIDTH-1:0] gcd_q;

  logic [WIDTH-1:0] a_nxt, b_nxt;
  logic             term;
  logic [WIDTH-1:0] gcd_full;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a     (a),
    .b     (b),
    .a_nxt (a_nxt),
    .b_nxt (b_nxt),
    .term  (term)
  );

  // The common power of two removed in SHIFT is restored here.
  assign gcd_full = ((a == '0) ? b : a) << k;

  // NOTE: all state is updated with non-blocking assignments so every register sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      a          <= '0;
      b          <= '0;
      k          <= '0;
      prime_flag <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      e_valid_q  <= 1'b0;
      gcd_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a          <= bus.e;
            b          <= bus.phi;
            prime_flag <= bus.e_is_prime;
            k          <= '0;
            busy_q     <= 1'b1;
            state      <= ST_PRECHK;
          end
        end
        ST_PRECHK: begin
          if (!prime_flag || (a < WIDTH'(2)) || (a >= b)) begin
            gcd_q     <= '0;
            e_valid_q <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state     <= ST_FINISH;
          end else begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!a[0] && !b[0]) begin
            a <= a >> 1;
            b <= b >> 1;
            k <= k + CNT_W'(1);
          end else begin
            state <= ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          if (term) begin
            gcd_q     <= gcd_full;
            e_valid_q <= (gcd_full == WIDTH'(1));
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state     <= ST_FINISH;
          end else begin
            a <= a_nxt;
            b <= b_nxt;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.e_valid = e_valid_q;
  assign bus.gcd_out = gcd_q;

`ifdef COPRIME_CYCLE_CNT_EN
  logic [CNT_W-1:0] cycles_q;

  // Loaded with 1 on start so the PRECHK cycle is already counted; the FINISH cycle
  // is added on the way out of the last working state, so the value is final at done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycles_q <= '0;
    end else if (state == ST_IDLE) begin
      if (bus.start) cycles_q <= CNT_W'(1);
    end else if (state != ST_FINISH && cycles_q != '1) begin
      cycles_q <= cycles_q + CNT_W'(1);
    end
  end

  assign bus.cycles = cycles_q;
`endif

endmodule

// File: tb/tb_coprime_exp_check.sv
// Randomized self-checking bench for coprime_exp_check against a Euclid-based model.
// Define COPRIME_CYCLE_CNT_EN to also check the cycle counter.
module tb_coprime_exp_check;
  import rsa_pkg::*;

  localparam int W = RSA_W;

  logic clk;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  coprime_exp_check_if #(.WIDTH(W), .CNT_W(RSA_CNT_W)) bus ();

  coprime_exp_check #(.WIDTH(W), .CNT_W(RSA_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: pre-check rules plus Euclid's remainder GCD.
  function automatic void ref_model(input logic [W-1:0] ev, input logic pv,
                                    input logic [W-1:0] phv, output logic [W-1:0] g,
                                    output logic v, output bit rej);
    logic [W-1:0] x, y, t;
    rej = !pv || (ev <= 1) || (ev >= phv);
    g = '0;
    v = 1'b0;
    if (rej) return;
    x = ev;
    y = phv;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    g = x;
    v = (x == 1);
  endfunction

  // Drives one request and returns at the negedge of the done cycle (or on timeout).
  // lat counts clock cycles from the start cycle up to and including the done cycle.
  task automatic run_op(input logic [W-1:0] ev, input logic pv, input logic [W-1:0] phv,
                        input bit poke_start, output logic [W-1:0] g, output logic v,
                        output int lat, output bit got_done);
    @(negedge clk);
    bus.start = 1'b1; bus.e = ev; bus.e_is_prime = pv; bus.phi = phv;
    lat = 1;
    @(negedge clk);
    lat = 2;
    bus.start = 1'b0; bus.e = rand_w(); bus.phi = rand_w(); bus.e_is_prime = ~pv;
    while (!bus.done && lat < RSA_MAX_LAT + 2) begin
      bus.start = poke_start && (lat == 6);
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    got_done = bus.done;
    g = bus.gcd_out;
    v = bus.e_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.e = '0; bus.phi = '0; bus.e_is_prime = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 4;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    if (bus.e_valid !== 1'b0) begin miscompares++; $display("FAIL reset_e_valid got=%b exp=0", bus.e_valid); end
    if (bus.gcd_out !== '0) begin miscompares++; $display("FAIL reset_gcd got=%0h exp=0", bus.gcd_out); end
    rst_n = 1'b1;
  endtask

  // Directed table: accept/reject and the SHIFT path.
  task automatic test_directed();
    logic [W-1:0] te [7]; logic tp [7]; logic [W-1:0] tphi [7];
    logic [W-1:0] g, eg; logic v, ev; int lat; bit gd, rej;
    te[0] = 3;  tp[0] = 1; tphi[0] = 20;
    te[1] = 5;  tp[1] = 1; tphi[1] = 20;
    te[2] = 4;  tp[2] = 0; tphi[2] = 20;
    te[3] = 1;  tp[3] = 1; tphi[3] = 20;
    te[4] = 20; tp[4] = 1; tphi[4] = 20;
    te[5] = 2;  tp[5] = 1; tphi[5] = 12;
    te[6] = 7;  tp[6] = 1; tphi[6] = 0;
    for (int i = 0; i < 7; i++) begin
      ref_model(te[i], tp[i], tphi[i], eg, ev, rej);
      run_op(te[i], tp[i], tphi[i], 1'b0, g, v, lat, gd);
      vectors += 4;
      if (!gd) begin miscompares++; $display("FAIL dir%0d_done got=no_done exp=done", i); end
      if (g !== eg) begin miscompares++; $display("FAIL dir%0d_gcd got=%0h exp=%0h", i, g, eg); end
      if (v !== ev) begin miscompares++; $display("FAIL dir%0d_valid got=%b exp=%b", i, v, ev); end
      if (rej ? (lat != 3) : (lat > RSA_MAX_LAT)) begin
        miscompares++; $display("FAIL dir%0d_latency got=%0d rej=%0d", i, lat, rej);
      end
`ifdef COPRIME_CYCLE_CNT_EN
      vectors++;
      if (bus.cycles !== RSA_CNT_W'(lat - 1)) begin
        miscompares++; $display("FAIL dir%0d_cycles got=%0d exp=%0d", i, bus.cycles, lat - 1);
      end
`endif
    end
  endtask

  task automatic test_big_exponent();
    logic [W-1:0] phv, g; logic v; int lat; bit gd;
    phv = '0; phv[W-1] = 1'b1; phv = phv - 2;
    run_op(65537, 1'b1, phv, 1'b1, g, v, lat, gd);
    vectors += 4;
    if (!gd) begin miscompares++; $display("FAIL big_done got=no_done exp=done"); end
    if (g !== W'(1)) begin miscompares++; $display("FAIL big_gcd got=%0h exp=1", g); end
    if (v !== 1'b1) begin miscompares++; $display("FAIL big_valid got=%b exp=1", v); end
    if (lat > RSA_MAX_LAT) begin miscompares++; $display("FAIL big_latency got=%0d max=%0d", lat, RSA_MAX_LAT); end
    @(negedge clk);
    vectors += 3;
    if (bus.done !== 1'b0) begin miscompares++; $display("FAIL big_done_pulse got=%b exp=0", bus.done); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL big_no_queue got=%b exp=0", bus.busy); end
    if (bus.e_valid !== 1'b1) begin miscompares++; $display("FAIL big_hold got=%b exp=1", bus.e_valid); end
  endtask

  task automatic test_random();
    logic [W-1:0] ev, phv, g, eg; logic pv, v, xv; int lat, mode, f; bit gd, rej;
    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(0, 3);
      pv = 1'b1;
      case (mode)
        0: begin ev = W'($urandom_range(2, 100000) | 1); phv = rand_w(); end
        1: begin
          f = $urandom_range(2, 12);
          ev = W'(f * $urandom_range(1, 3000));
          phv = (rand_w() >> 8) * W'(f);
        end
        2: begin ev = rand_w() >> $urandom_range(0, 255); phv = rand_w(); pv = 1'($urandom); end
        default: begin
          phv = W'($urandom_range(0, 50));
          ev = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 1)) : phv + W'($urandom_range(0, 3));
        end
      endcase
      ref_model(ev, pv, phv, eg, xv, rej);
      run_op(ev, pv, phv, 1'b0, g, v, lat, gd);
      vectors += 4;
      if (!gd) begin miscompares++; $display("FAIL rnd%0d_done got=no_done exp=done", it); end
      if (g !== eg) begin miscompares++; $display("FAIL rnd%0d_gcd got=%0h exp=%0h", it, g, eg); end
      if (v !== xv) begin miscompares++; $display("FAIL rnd%0d_valid got=%b exp=%b", it, v, xv); end
      if (rej ? (lat != 3) : (lat > RSA_MAX_LAT)) begin
        miscompares++; $display("FAIL rnd%0d_latency got=%0d rej=%0d", it, lat, rej);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] phv, g; logic v; int lat, seen; bit gd;
    phv = '0; phv[W-1] = 1'b1; phv = phv - 2;
    run_op(3, 1'b1, 20, 1'b0, g, v, lat, gd);
    @(negedge clk);
    bus.start = 1'b1; bus.e = 65537; bus.e_is_prime = 1'b1; bus.phi = phv;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors += 4;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mrst_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin miscompares++; $display("FAIL mrst_done got=%b exp=0", bus.done); end
    if (bus.e_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_valid got=%b exp=0", bus.e_valid); end
    if (bus.gcd_out !== '0) begin miscompares++; $display("FAIL mrst_gcd got=%0h exp=0", bus.gcd_out); end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL mrst_aborted got=%0d active_cycles exp=0", seen); end
    run_op(65537, 1'b1, phv, 1'b0, g, v, lat, gd);
    vectors += 3;
    if (!gd) begin miscompares++; $display("FAIL mrst_rerun_done got=no_done exp=done"); end
    if (g !== W'(1)) begin miscompares++; $display("FAIL mrst_rerun_gcd got=%0h exp=1", g); end
    if (v !== 1'b1) begin miscompares++; $display("FAIL mrst_rerun_valid got=%b exp=1", v); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] g; logic v; int lat; bit gd;
    run_op(3, 1'b1, 20, 1'b0, g, v, lat, gd);
    bus.start = 1'b1; bus.e = 5; bus.e_is_prime = 1'b1; bus.phi = 20;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_done_cycle_start got=%b exp=0", bus.busy); end
    @(negedge clk);
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept got=%b exp=1", bus.busy); end
    lat = 0;
    while (!bus.done && lat < RSA_MAX_LAT) begin
      @(negedge clk);
      lat++;
    end
    vectors += 3;
    if (!bus.done) begin miscompares++; $display("FAIL b2b_done got=no_done exp=done"); end
    if (bus.gcd_out !== W'(5)) begin miscompares++; $display("FAIL b2b_gcd got=%0h exp=5", bus.gcd_out); end
    if (bus.e_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid got=%b exp=0", bus.e_valid); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_big_exponent();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
